// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD array sequencer.
// The optional cycle counter in the top module is enabled by defining SAD_PERF_CNT_EN.
package sad_pkg;

  // Sequencer phases: address issue, pipeline drain, lane scan, completion pulse.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    SCAN  = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Default geometry of the array and the memories.
  localparam int N_PE_DEF = 8;
  localparam int TW_DEF   = 8;
  localparam int TH_DEF   = 8;
  localparam int IW_DEF   = 64;
  localparam int IH_DEF   = 64;

  // Width of one lane SAD result.
  localparam int SAD_W = 10;

  // Address and coordinate widths for the default geometry.
  localparam int T_AW = $clog2(TW_DEF * TH_DEF);
  localparam int I_AW = $clog2(IW_DEF * IH_DEF);
  localparam int X_W  = $clog2(IW_DEF);
  localparam int Y_W  = $clog2(IH_DEF);

  // Number of N_PE-wide column blocks needed to cover every candidate column.
  function automatic int num_blocks(input int iw, input int tw, input int npe);
    return (iw - tw + 1 + npe - 1) / npe;
  endfunction

endpackage

// File: rtl/sad_min_tracker.sv
// Running-minimum tracker: fed one lane SAD per scan cycle, keeps the strictly
// smallest value and its position. Lanes past the last valid column are ignored.
module sad_min_tracker
  import sad_pkg::*;
#(
  parameter int IW  = IW_DEF,
  parameter int TW  = TW_DEF,
  parameter int XW  = X_W,
  parameter int YW  = Y_W,
  parameter int LXW = X_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_i,
  input  logic             vld_i,
  input  logic [LXW-1:0]   lane_x_i,
  input  logic [YW-1:0]    y_i,
  input  logic [SAD_W-1:0] sad_i,
  output logic [SAD_W-1:0] best_sad_o,
  output logic [XW-1:0]    best_x_o,
  output logic [YW-1:0]    best_y_o
);

  logic [SAD_W-1:0] best_sad_q;
  logic [XW-1:0]    best_x_q;
  logic [YW-1:0]    best_y_q;
  logic             lane_ok;

  // A lane only competes when it holds a real candidate column.
  always_comb begin
    lane_ok = vld_i && (int'(lane_x_i) <= IW - TW);
  end

  // Strict-less update keeps the first minimum met in raster order.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_sad_q <= '0;
      best_x_q   <= '0;
      best_y_q   <= '0;
    end else if (init_i) begin
      best_sad_q <= '1;
      best_x_q   <= '0;
      best_y_q   <= '0;
    end else if (lane_ok && (sad_i < best_sad_q)) begin
      best_sad_q <= sad_i;
      best_x_q   <= XW'(lane_x_i);
      best_y_q   <= y_i;
    end
  end

  assign best_sad_o = best_sad_q;
  assign best_x_o   = best_x_q;
  assign best_y_o   = best_y_q;

endmodule

// File: rtl/sad_array_sequencer.sv
// Sequencer for a row of SAD processing elements: issues template/image
// addresses block by block, drives the PE pixel enable and accumulate select,
// then scans the lanes into the minimum tracker.
// Defining SAD_PERF_CNT_EN adds the perf_cycles_o busy-cycle counter.
// Handshake: start_i is a level sampled only in IDLE; done_o is a one-cycle
// pulse and best_* stay valid from that cycle until the next accepted start.
module sad_array_sequencer
  import sad_pkg::*;
#(
  parameter int N_PE = N_PE_DEF,
  parameter int TW   = TW_DEF,
  parameter int TH   = TH_DEF,
  parameter int IW   = IW_DEF,
  parameter int IH   = IH_DEF,
  localparam int TAW = $clog2(TW * TH),
  localparam int IAW = $clog2(IW * IH),
  localparam int XW  = $clog2(IW),
  localparam int YW  = $clog2(IH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [TAW-1:0]        t_addr_o,
  output logic [IAW-1:0]        i_addr_o,
  output logic                  mem_rd_o,
  output logic                  pix_en_o,
  output logic                  pe_acc_sel_o,
  input  logic [N_PE*SAD_W-1:0] pe_sad_i,
`ifdef SAD_PERF_CNT_EN
  output logic [31:0]           perf_cycles_o,
`endif
  output logic [SAD_W-1:0]      best_sad_o,
  output logic [XW-1:0]         best_x_o,
  output logic [YW-1:0]         best_y_o,
  output logic [2:0]            dbg_state_o
);

  localparam int TXW = $clog2(TW + 1);
  localparam int TYW = $clog2(TH + 1);
  localparam int CW  = $clog2(N_PE + 2);
  localparam int LXW = $clog2(IW + N_PE);

  state_e           state_q;
  logic [TXW-1:0]   tx_q, tx_n;
  logic [TYW-1:0]   ty_q, ty_n;
  logic [XW-1:0]    x0_q, x0_n;
  logic [YW-1:0]    y_q, y_n;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, mem_rd_q, pix_en_q, acc_sel_q;
  logic [TAW-1:0]   t_addr_q;
  logic [IAW-1:0]   i_addr_q;
  logic             accept, last_tx, last_pix, last_x, last_y;
  logic [IAW-1:0]   fetch_addr, block_addr;
  logic [SAD_W-1:0] lane_sad;
  logic [LXW-1:0]   lane_x;

  // Next pixel / next block positions and the addresses they map to.
  always_comb begin
    accept     = (state_q == IDLE) && start_i;
    last_tx    = int'(tx_q) == TW - 1;
    last_pix   = last_tx && (int'(ty_q) == TH - 1);
    tx_n       = last_tx ? '0 : tx_q + TXW'(1);
    ty_n       = last_tx ? ty_q + TYW'(1) : ty_q;
    fetch_addr = IAW'((int'(y_q) + int'(ty_n)) * IW + int'(x0_q) + int'(tx_n));
    last_x     = int'(x0_q) + N_PE > IW - TW;
    last_y     = int'(y_q) == IH - TH;
    x0_n       = last_x ? '0 : XW'(int'(x0_q) + N_PE);
    y_n        = last_x ? y_q + YW'(1) : y_q;
    block_addr = IAW'(int'(y_n) * IW + int'(x0_n));
    lane_sad   = pe_sad_i[int'(cnt_q) * SAD_W +: SAD_W];
    lane_x     = LXW'(int'(x0_q) + int'(cnt_q));
  end

  // Main FSM; pix_en/acc_sel trail the issued address by one cycle so they
  // line up with read data, and the first pixel of a block restarts the PE sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      ty_q      <= '0;
      x0_q      <= '0;
      y_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mem_rd_q  <= 1'b0;
      pix_en_q  <= 1'b0;
      acc_sel_q <= 1'b1;
      t_addr_q  <= '0;
      i_addr_q  <= '0;
    end else begin
      pix_en_q  <= mem_rd_q;
      acc_sel_q <= mem_rd_q ? (t_addr_q != '0) : 1'b1;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q  <= FETCH;
            busy_q   <= 1'b1;
            mem_rd_q <= 1'b1;
            tx_q     <= '0;
            ty_q     <= '0;
            x0_q     <= '0;
            y_q      <= '0;
            t_addr_q <= '0;
            i_addr_q <= '0;
          end
        end
        FETCH: begin
          if (last_pix) begin
            state_q  <= DRAIN;
            mem_rd_q <= 1'b0;
            cnt_q    <= '0;
          end else begin
            tx_q     <= tx_n;
            ty_q     <= ty_n;
            t_addr_q <= t_addr_q + TAW'(1);
            i_addr_q <= fetch_addr;
          end
        end
        DRAIN: begin
          if (int'(cnt_q) == 1) begin
            state_q <= SCAN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        SCAN: begin
          if (int'(cnt_q) == N_PE - 1) begin
            cnt_q <= '0;
            if (last_x && last_y) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q  <= FETCH;
              mem_rd_q <= 1'b1;
              tx_q     <= '0;
              ty_q     <= '0;
              x0_q     <= x0_n;
              y_q      <= y_n;
              t_addr_q <= '0;
              i_addr_q <= block_addr;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  sad_min_tracker #(
    .IW (IW),
    .TW (TW),
    .XW (XW),
    .YW (YW),
    .LXW(LXW)
  ) u_min (
    .clk       (clk),
    .rst       (rst),
    .init_i    (accept),
    .vld_i     (state_q == SCAN),
    .lane_x_i  (lane_x),
    .y_i       (y_q),
    .sad_i     (lane_sad),
    .best_sad_o(best_sad_o),
    .best_x_o  (best_x_o),
    .best_y_o  (best_y_o)
  );

`ifdef SAD_PERF_CNT_EN
  logic [31:0] perf_q;

  // Busy-cycle counter, cleared on accepted start, saturating, held after done.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (accept) begin
      perf_q <= '0;
    end else if (busy_q && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_q;
`endif

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign mem_rd_o     = mem_rd_q;
  assign pix_en_o     = pix_en_q;
  assign pe_acc_sel_o = acc_sel_q;
  assign t_addr_o     = t_addr_q;
  assign i_addr_o     = i_addr_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_sad_array_sequencer.sv
// Bench for sad_array_sequencer on a small 8x8 image / 2x2 template with 4 lanes.
// Models the memories and PE row, predicts the per-cycle control outputs from
// the block timing, and predicts the search result by brute-force SAD.
module tb_sad_array_sequencer;

  localparam int N_PE  = 4;
  localparam int TW    = 2;
  localparam int TH    = 2;
  localparam int IW    = 8;
  localparam int IH    = 8;
  localparam int SAD_W = 10;
  localparam int TAW   = 2;
  localparam int IAW   = 6;
  localparam int XW    = 3;
  localparam int YW    = 3;
  localparam int NPIX  = TW * TH;
  localparam int NB    = (IW - TW + 1 + N_PE - 1) / N_PE;
  localparam int BLK   = NPIX + 2 + N_PE;
  localparam int DONE_CYC = 1 + NB * (IH - TH + 1) * BLK;
  localparam int EW    = SAD_W + XW + YW;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  logic start_i;
  always #5 clk = ~clk;

  logic                  busy_o, done_o, mem_rd_o, pix_en_o, pe_acc_sel_o;
  logic [TAW-1:0]        t_addr_o;
  logic [IAW-1:0]        i_addr_o;
  logic [N_PE*SAD_W-1:0] pe_sad;
  logic [SAD_W-1:0]      best_sad_o;
  logic [XW-1:0]         best_x_o;
  logic [YW-1:0]         best_y_o;
  logic [2:0]            dbg_state_o;
`ifdef SAD_PERF_CNT_EN
  logic [31:0]           perf_cycles_o;
`endif

  sad_array_sequencer #(
    .N_PE(N_PE), .TW(TW), .TH(TH), .IW(IW), .IH(IH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .t_addr_o    (t_addr_o),
    .i_addr_o    (i_addr_o),
    .mem_rd_o    (mem_rd_o),
    .pix_en_o    (pix_en_o),
    .pe_acc_sel_o(pe_acc_sel_o),
    .pe_sad_i    (pe_sad),
`ifdef SAD_PERF_CNT_EN
    .perf_cycles_o(perf_cycles_o),
`endif
    .best_sad_o  (best_sad_o),
    .best_x_o    (best_x_o),
    .best_y_o    (best_y_o),
    .dbg_state_o (dbg_state_o)
  );

  // Memories and PE row
  bit               img [IW*IH];
  bit               tmpl[NPIX];
  bit               t_bit;
  bit               i_bits[N_PE];
  logic [SAD_W-1:0] pe_reg[N_PE];

  initial begin
    for (int k = 0; k < N_PE; k++) pe_reg[k] = '0;
  end

  always @(posedge clk) begin
    if (mem_rd_o) begin
      t_bit <= tmpl[t_addr_o];
      for (int k = 0; k < N_PE; k++)
        i_bits[k] <= (int'(i_addr_o) + k < IW * IH) ? img[int'(i_addr_o) + k] : 1'b0;
    end
    if (pix_en_o || !pe_acc_sel_o) begin
      for (int k = 0; k < N_PE; k++)
        pe_reg[k] <= (pe_acc_sel_o ? pe_reg[k] : '0) +
                     ((pix_en_o && (t_bit != i_bits[k])) ? SAD_W'(1) : SAD_W'(0));
    end
  end

  always_comb begin
    pe_sad = '0;
    for (int k = 0; k < N_PE; k++) pe_sad[k*SAD_W +: SAD_W] = pe_reg[k];
  end

  // Scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] m_best;
  int  m_cyc   = -1;
  bit  m_addr0 = 1'b1;
  bit  chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // Brute-force minimum SAD, first minimum in raster order.
  function automatic logic [EW-1:0] ref_best();
    int best = 1 << 30;
    int bx = 0;
    int by = 0;
    for (int y = 0; y <= IH - TH; y++)
      for (int x = 0; x <= IW - TW; x++) begin
        int s = 0;
        for (int ty = 0; ty < TH; ty++)
          for (int tx = 0; tx < TW; tx++)
            if (tmpl[ty*TW+tx] != img[(y+ty)*IW + x + tx]) s++;
        if (s < best) begin best = s; bx = x; by = y; end
      end
    return {SAD_W'(best), XW'(bx), YW'(by)};
  endfunction

  // Cycle position of the current search as defined by the block timing.
  always @(posedge clk) begin
    if (rst) begin
      m_cyc   = -1;
      m_best  = '0;
      m_addr0 = 1'b1;
      exp_q.delete();
    end else if (m_cyc == -1) begin
      if (start_i) begin m_cyc = 1; m_addr0 = 1'b0; end
    end else if (m_cyc == DONE_CYC) begin
      m_cyc = -1;
    end else begin
      m_cyc++;
    end
  end

  // Per-cycle compare of every control output against the timing model.
  always @(negedge clk) begin
    if (chk_en) begin
      if (m_cyc < 1) begin
        chk("busy_idle", busy_o, 0);
        chk("done_idle", done_o, 0);
        chk("mem_rd_idle", mem_rd_o, 0);
        chk("pix_en_idle", pix_en_o, 0);
        chk("acc_sel_idle", pe_acc_sel_o, 1);
        if (m_addr0) begin
          chk("t_addr_rst", t_addr_o, 0);
          chk("i_addr_rst", i_addr_o, 0);
        end
        chk("best_hold", {best_sad_o, best_x_o, best_y_o}, m_best);
      end else if (m_cyc == DONE_CYC) begin
        chk("busy_done", busy_o, 0);
        chk("done_pulse", done_o, 1);
        chk("mem_rd_done", mem_rd_o, 0);
        chk("pix_en_done", pix_en_o, 0);
        chk("acc_sel_done", pe_acc_sel_o, 1);
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL exp_q_empty t=%0t actual=done required=queued_result", $time);
        end else begin
          m_best = exp_q.pop_front();
          chk("best_result", {best_sad_o, best_x_o, best_y_o}, m_best);
        end
`ifdef SAD_PERF_CNT_EN
        chk("perf_at_done", perf_cycles_o, DONE_CYC - 1);
`endif
      end else begin
        int ph, b, row, bx, tx, ty, ia;
        ph  = (m_cyc - 1) % BLK;
        b   = (m_cyc - 1) / BLK;
        row = b / NB;
        bx  = b % NB;
        chk("busy_run", busy_o, 1);
        chk("done_run", done_o, 0);
        chk("mem_rd_run", mem_rd_o, (ph < NPIX) ? 1 : 0);
        chk("pix_en_run", pix_en_o, (ph >= 1 && ph <= NPIX) ? 1 : 0);
        chk("acc_sel_run", pe_acc_sel_o, (ph == 1) ? 0 : 1);
        if (ph < NPIX) begin
          tx = ph % TW;
          ty = ph / TW;
          ia = ((row + ty) * IW + bx * N_PE + tx) % (IW * IH);
          chk("t_addr_run", t_addr_o, ph);
          chk("i_addr_run", i_addr_o, ia);
        end
      end
    end
  end

  // Driver tasks
  task automatic clear_img();
    for (int i = 0; i < IW * IH; i++) img[i] = 1'b0;
  endtask

  task automatic set_px(input int x, input int y);
    img[y*IW + x] = 1'b1;
  endtask

  task automatic rand_img();
    for (int i = 0; i < IW * IH; i++) img[i] = bit'($urandom_range(0, 1));
    for (int i = 0; i < NPIX; i++) tmpl[i] = bit'($urandom_range(0, 1));
  endtask

  task automatic run_search(input bit mid_pulse, input bit done_pulse, input int abort_at);
    int cyc;
    bit seen;
    exp_q.push_back(ref_best());
    @(negedge clk) start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (cyc < DONE_CYC + 50 && !seen) begin
      if (cyc == abort_at) begin
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("abort_best_sad", best_sad_o, 0);
        chk("abort_busy", busy_o, 0);
        return;
      end
      if (cyc == 1) chk("busy_c1", busy_o, 1);
      if (cyc == 2) chk("acc_sel_c2", pe_acc_sel_o, 0);
      if (cyc == 5) chk("pix_en_c5", pix_en_o, 1);
      if (cyc == 6) chk("pix_en_c6", pix_en_o, 0);
      if (done_o) begin
        seen = 1'b1;
      end else begin
        start_i = mid_pulse && (cyc == 20);
        @(negedge clk) start_i = 1'b0;
        cyc++;
      end
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout actual=no_done required=done_at_%0d", DONE_CYC);
    end else begin
      chk("done_cycle", cyc, DONE_CYC);
      if (done_pulse) begin
        start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
      end
      repeat (3) @(negedge clk);
    end
  endtask

  // Test sequence
  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    clear_img();
    for (int i = 0; i < NPIX; i++) tmpl[i] = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_best_sad", best_sad_o, 0);
    chk("rst_pe_acc_sel", pe_acc_sel_o, 1);
    rst = 1'b0;
    @(negedge clk);

    // Diagonal template, single exact match at (5,3).
    tmpl[0] = 1'b1; tmpl[1] = 1'b0; tmpl[2] = 1'b0; tmpl[3] = 1'b1;
    clear_img(); set_px(5, 3); set_px(6, 4);
    chk("pin_ref_a", ref_best(), {10'd0, 3'd5, 3'd3});
    run_search(1'b0, 1'b0, 0);
    chk("lit_a", {best_sad_o, best_x_o, best_y_o}, {10'd0, 3'd5, 3'd3});

    // Two exact matches on row 2: the left one wins.
    clear_img(); set_px(1, 2); set_px(2, 3); set_px(4, 2); set_px(5, 3);
    run_search(1'b0, 1'b0, 0);
    chk("lit_b", {best_sad_o, best_x_o, best_y_o}, {10'd0, 3'd1, 3'd2});

    // A masked lane (x=7) would see a perfect match; real best is SAD 1 at (0,2).
    clear_img(); set_px(7, 0); set_px(0, 2);
    chk("pin_ref_c", ref_best(), {10'd1, 3'd0, 3'd2});
    run_search(1'b0, 1'b0, 0);
    chk("lit_c", {best_sad_o, best_x_o, best_y_o}, {10'd1, 3'd0, 3'd2});

    // Random content with start pulsed mid-search and in the done cycle.
    rand_img();
    run_search(1'b1, 1'b1, 0);

    // Abort in cycle 50, then a complete search on the same content.
    rand_img();
    run_search(1'b0, 1'b0, 50);
    repeat (2) @(negedge clk);
    run_search(1'b0, 1'b0, 0);

    for (int r = 0; r < 2; r++) begin
      rand_img();
      run_search(1'b0, 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sad_array_sequencer.md
# sad_array_sequencer

Controller for a row of N_PE SAD processing elements matching a binary template against a binary image. It issues template and image memory addresses, drives the shared accumulate/restart select and pixel-enable into the array, and scans the lane results after each block. It also tracks the minimum SAD and its (x,y) position, reporting them with a done pulse. It sits between the frame/template memories and the PE array and is the only sequencing logic the array needs.

## Interface
- N_PE, 8: PE lanes; lane k evaluates candidate column x0+k
- TW, 8: template width in pixels
- TH, 8: template height in pixels
- IW, 64: image width in pixels
- IH, 64: image height in pixels
- SAD_W, 10: width of a lane SAD result
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a search; sampled only in IDLE
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse, results valid from this cycle until next start
- t_addr  out  clog2(TW*TH)  template bit address, ty*TW+tx
- i_addr  out  clog2(IW*IH)  image base bit address, (y+ty)*IW+(x0+tx); memory returns N_PE bits from the base
- mem_rd  out  1  address valid; read data returns next cycle
- pix_en  out  1  array gates pixel difference to 0 when low
- pe_acc_sel  out  1  drives PE select_s: 1 = add to own register, 0 = restart from zero input
- pe_sad  in  N_PE*SAD_W  lane results, lane k at [k*SAD_W +: SAD_W]
- best_sad  out  SAD_W  minimum SAD found
- best_x  out  clog2(IW)  column of best_sad
- best_y  out  clog2(IH)  row of best_sad

## Operation
- Candidates: y in 0..IH-TH, x in 0..IW-TW. Blocks: x0 = 0, N_PE, 2*N_PE..., NB = ceil((IW-TW+1)/N_PE) per row. Rows are outer, blocks inner.
- States: IDLE -> FETCH on start. FETCH issues TW*TH addresses, with tx inner and ty outer, one per cycle, then goes to DRAIN. DRAIN lasts 2 cycles, then goes to SCAN. SCAN lasts N_PE cycles and reads lane k in scan cycle k. After SCAN the FSM goes to FETCH for the next block, or to DONE after the last block. DONE lasts 1 cycle with the done pulse, then returns to IDLE.
- Pixel alignment: if pixel p's address is issued in cycle c, then in cycle c+1 the block drives pix_en=1 and pe_acc_sel=(p!=0). The PE register holds the updated sum at c+2.
- Outside those cycles: pix_en=0 and pe_acc_sel=1, so the PE registers hold their value.
- Lane masking: a lane with x0+k > IW-TW is skipped in SCAN and never updates best.
- Compare rule: update only if lane SAD < best_sad (strict). The first minimum in raster order (y, then x) wins.
- best_sad is initialised to all-ones at start. Lane values are at most the PE saturation value, so the first valid lane always updates.
- Reset values: busy=0, done=0, mem_rd=0, pix_en=0, pe_acc_sel=1, t_addr=0, i_addr=0, best_sad=0, best_x=0, best_y=0, FSM=IDLE.
- rst mid-search aborts immediately to the reset state. No done pulse is produced for the aborted search.
- start while busy is ignored. start in the done cycle is also ignored; it is accepted the following cycle.

## Timing
- Accepted start is in cycle 0. The first FETCH cycle is cycle 1 and busy rises in cycle 1.
- Cycles per block: TW*TH + 2 + N_PE.
- done cycle: 1 + NB*(IH-TH+1)*(TW*TH+2+N_PE). busy falls in the same cycle.
- All outputs are registered; no combinational path from pe_sad to outputs.

## Configuration
- SAD_PERF_CNT_EN defined: adds output perf_cycles [31:0]. It clears on accepted start, increments every busy cycle, saturates at 2^32-1, and holds after done. At done it equals the busy-cycle count.
- SAD_PERF_CNT_EN not defined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Shared package sad_pkg holds: the FSM state enum (IDLE, FETCH, DRAIN, SCAN, DONE), SAD_W, and clog2-derived address-width localparams.
- One sub-module, sad_min_tracker, holds best_sad/best_x/best_y, the strict-less compare and lane masking. It is fed one lane per SCAN cycle.
- Address generation and the FSM stay in the top module.

## Test plan
- N_PE=4, TW=TH=2, IW=IH=8; start in cycle 0 -> busy in cycles 1..140, done pulse in cycle 141, 14 blocks, lane 3 of odd blocks (x=7) never compared.
- Image equal to the template placed at (5,3), all other pixels differing -> best_sad=0, best_x=5, best_y=3.
- Two exact matches at (1,2) and (4,2) -> best_x=1, best_y=2 (first in raster order wins).
- First FETCH of a block: pe_acc_sel=0 exactly one cycle after t_addr=0 is issued, pix_en high for 4 cycles, then pix_en=0 and pe_acc_sel=1 through DRAIN/SCAN.
- rst asserted in cycle 50 -> next cycle all outputs at reset values; no done; a new start runs a full 140-cycle search.
- With SAD_PERF_CNT_EN: perf_cycles=140 at done; start pulsed during busy -> no restart, count unchanged.
